// File: rtl/oled_page_composer.sv
`timescale 1ns/1ps
// Formats credit / item / status into four 16-char ASCII pages and drives the OLED EN/FIN handshake.
// Optional periodic forced redraw: define REFRESH_TIMER_EN.
module oled_page_composer #(
    parameter int unsigned BLANK_LEAD = 1
`ifdef REFRESH_TIMER_EN
    ,
    parameter int unsigned REFRESH_CYCLES = 50000000
`endif
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [13:0]  CREDIT,
    input  logic [3:0]   ITEM_SEL,
    input  logic [1:0]   MSG,
    input  logic         OLED_FIN,
    output logic         OLED_EN,
    output logic [127:0] PAGE0,
    output logic [127:0] PAGE1,
    output logic [127:0] PAGE2,
    output logic [127:0] PAGE3,
    output logic         BUSY
);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StConvert,
        StBuild,
        StStart,
        StWaitFin,
        StRelease
    } state_e;

    localparam logic [127:0] Blank      = {16{8'h20}};
    localparam logic [127:0] Title      = "VENDING MACHINE ";
    localparam logic [71:0]  CreditHdr  = "CREDIT: $";
    localparam logic [47:0]  ItemHdr    = "ITEM: ";
    localparam logic [127:0] MsgIdle    = "INSERT COINS    ";
    localparam logic [127:0] MsgVending = "VENDING...      ";
    localparam logic [127:0] MsgSoldOut = "SOLD OUT        ";
    localparam logic [127:0] MsgNoCred  = "NO CREDIT       ";

`ifdef REFRESH_TIMER_EN
    localparam int unsigned CntW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_CYCLES - 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    state_e       state_q, state_d;
    logic         en_q, en_d;
    logic         dirty_q, dirty_d;
    logic [13:0]  snap_credit_q, snap_credit_d;
    logic [3:0]   snap_item_q, snap_item_d;
    logic [1:0]   snap_msg_q, snap_msg_d;
    // {BCD D3..D0, binary} shift register for double-dabble
    logic [29:0]  dd_q, dd_d;
    logic [3:0]   step_q, step_d;
    logic [127:0] page0_q, page0_d;
    logic [127:0] page1_q, page1_d;
    logic [127:0] page2_q, page2_d;
    logic [127:0] page3_q, page3_d;

    logic         changed;
    logic [13:0]  credit_sat;
    logic [7:0]   tens_ch;
    logic [7:0]   item_ch;
    logic [127:0] msg_page;

    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [29:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[14+4*i +: 4] >= 4'd5) begin
                r[14+4*i +: 4] = r[14+4*i +: 4] + 4'd3;
            end
        end
        return {r[28:0], 1'b0};
    endfunction

    assign changed    = {CREDIT, ITEM_SEL, MSG} != {snap_credit_q, snap_item_q, snap_msg_q};
    assign credit_sat = (CREDIT > 14'd9999) ? 14'd9999 : CREDIT;

    always_comb begin
        tens_ch = {4'h3, dd_q[29:26]};
        if ((BLANK_LEAD != 0) && (dd_q[29:26] == 4'd0)) begin
            tens_ch = 8'h20;
        end
        if (snap_item_q == 4'd0) begin
            item_ch = 8'h2d;
        end else if (snap_item_q <= 4'd9) begin
            item_ch = {4'h3, snap_item_q};
        end else begin
            item_ch = 8'h3f;
        end
        unique case (snap_msg_q)
            2'd0:    msg_page = MsgIdle;
            2'd1:    msg_page = MsgVending;
            2'd2:    msg_page = MsgSoldOut;
            default: msg_page = MsgNoCred;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        en_d          = en_q;
        dirty_d       = dirty_q;
        snap_credit_d = snap_credit_q;
        snap_item_d   = snap_item_q;
        snap_msg_d    = snap_msg_q;
        dd_d          = dd_q;
        step_d        = step_q;
        page0_d       = page0_q;
        page1_d       = page1_q;
        page2_d       = page2_q;
        page3_d       = page3_q;
`ifdef REFRESH_TIMER_EN
        cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CntMax) begin
            dirty_d = 1'b1;
        end
`endif
        // Changes seen once the snapshot is taken leave a pending refresh behind
        if (changed && (state_q != StIdle) && (state_q != StLatch)) begin
            dirty_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (dirty_q || changed) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                snap_credit_d = CREDIT;
                snap_item_d   = ITEM_SEL;
                snap_msg_d    = MSG;
                dirty_d       = 1'b0;
                dd_d          = {16'h0000, credit_sat};
                step_d        = 4'd0;
                state_d       = StConvert;
`ifdef REFRESH_TIMER_EN
                cnt_d         = '0;
`endif
            end
            StConvert: begin
                dd_d   = dd_step(dd_q);
                step_d = step_q + 4'd1;
                if (step_q == 4'd13) begin
                    state_d = StBuild;
                end
            end
            StBuild: begin
                page0_d = Title;
                page1_d = {CreditHdr, tens_ch, {4'h3, dd_q[25:22]}, 8'h2e,
                           {4'h3, dd_q[21:18]}, {4'h3, dd_q[17:14]}, 16'h2020};
                page2_d = {ItemHdr, item_ch, {9{8'h20}}};
                page3_d = msg_page;
                state_d = StStart;
            end
            StStart: begin
                en_d    = 1'b1;
                state_d = StWaitFin;
            end
            StWaitFin: begin
                if (OLED_FIN) begin
                    en_d    = 1'b0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!OLED_FIN) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            en_q          <= 1'b0;
            dirty_q       <= 1'b1;
            snap_credit_q <= '0;
            snap_item_q   <= '0;
            snap_msg_q    <= '0;
            dd_q          <= '0;
            step_q        <= '0;
            page0_q       <= Blank;
            page1_q       <= Blank;
            page2_q       <= Blank;
            page3_q       <= Blank;
`ifdef REFRESH_TIMER_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            en_q          <= en_d;
            dirty_q       <= dirty_d;
            snap_credit_q <= snap_credit_d;
            snap_item_q   <= snap_item_d;
            snap_msg_q    <= snap_msg_d;
            dd_q          <= dd_d;
            step_q        <= step_d;
            page0_q       <= page0_d;
            page1_q       <= page1_d;
            page2_q       <= page2_d;
            page3_q       <= page3_d;
`ifdef REFRESH_TIMER_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign OLED_EN = en_q;
    assign PAGE0   = page0_q;
    assign PAGE1   = page1_q;
    assign PAGE2   = page2_q;
    assign PAGE3   = page3_q;
    assign BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_oled_page_composer.sv
`timescale 1ns/1ps
// Scoreboard bench for oled_page_composer: expected pages queued at stimulus, checked at each EN rise.
module tb_oled_page_composer;

    localparam int unsigned FinDelay = 100;
    localparam logic [127:0] Blank = {16{8'h20}};
    localparam logic [127:0] Title = "VENDING MACHINE ";

    typedef struct {
        logic [127:0] p1;
        logic [127:0] p2;
        logic [127:0] p3;
        int           exp_cyc;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic [13:0]  CREDIT;
    logic [3:0]   ITEM_SEL;
    logic [1:0]   MSG;
    logic         OLED_FIN;
    logic         OLED_EN;
    logic [127:0] PAGE0, PAGE1, PAGE2, PAGE3;
    logic         BUSY;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int hs_count = 0;
    int n_pushed = 0;
    int timer_hs = 0;
    int fin_cnt = 0;
    logic en_prev = 1'b0;
    exp_t sbq[$];
    exp_t last_exp;
    exp_t mon_e;
    logic [127:0] held0, held1, held2, held3;

    oled_page_composer #(
        .BLANK_LEAD(1)
`ifdef REFRESH_TIMER_EN
        ,
        .REFRESH_CYCLES(1000)
`endif
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .CREDIT(CREDIT),
        .ITEM_SEL(ITEM_SEL),
        .MSG(MSG),
        .OLED_FIN(OLED_FIN),
        .OLED_EN(OLED_EN),
        .PAGE0(PAGE0),
        .PAGE1(PAGE1),
        .PAGE2(PAGE2),
        .PAGE3(PAGE3),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    task automatic chk_page(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" required \"%s\"", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Driver stub: FIN rises FinDelay cycles after EN, held until EN falls
    initial begin
        OLED_FIN = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (RST || !OLED_EN) begin
                OLED_FIN = 1'b0;
                fin_cnt  = 0;
            end else if (!OLED_FIN) begin
                fin_cnt++;
                if (fin_cnt >= FinDelay) OLED_FIN = 1'b1;
            end
        end
    end

    // Monitor: pop and compare on every EN rise; pages must hold while EN is high
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                en_prev = 1'b0;
            end else begin
                if (OLED_EN && !en_prev) begin
                    hs_count++;
                    chk_page("page0", PAGE0, Title);
                    if (sbq.size() > 0) begin
                        mon_e    = sbq.pop_front();
                        last_exp = mon_e;
                        chk_page("page1", PAGE1, mon_e.p1);
                        chk_page("page2", PAGE2, mon_e.p2);
                        chk_page("page3", PAGE3, mon_e.p3);
                        if (mon_e.exp_cyc >= 0) chk_int("en_latency_cycle", cyc, mon_e.exp_cyc);
                    end else begin
`ifdef REFRESH_TIMER_EN
                        timer_hs++;
                        chk_page("timer_page1", PAGE1, last_exp.p1);
                        chk_page("timer_page2", PAGE2, last_exp.p2);
                        chk_page("timer_page3", PAGE3, last_exp.p3);
`else
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_handshake: EN rose at cycle %0d, required none", cyc);
`endif
                    end
                    held0 = PAGE0;
                    held1 = PAGE1;
                    held2 = PAGE2;
                    held3 = PAGE3;
                end else if (OLED_EN) begin
                    chk_page("page0_hold", PAGE0, held0);
                    chk_page("page1_hold", PAGE1, held1);
                    chk_page("page2_hold", PAGE2, held2);
                    chk_page("page3_hold", PAGE3, held3);
                end
                en_prev = OLED_EN;
            end
        end
    end

    task automatic wait_idle();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 3000 && quiet < 3; i++) begin
            @(negedge CLK);
            if (!BUSY && !OLED_FIN) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: BUSY=%0b, required 0 within 3000 cycles", BUSY);
        end
    endtask

    task automatic push_exp(input logic [127:0] e1, input logic [127:0] e2,
                            input logic [127:0] e3, input int ec);
        exp_t e;
        e.p1      = e1;
        e.p2      = e2;
        e.p3      = e3;
        e.exp_cyc = ec;
        sbq.push_back(e);
        n_pushed++;
    endtask

    // Applied in IDLE: first edge seeing the change is cyc+1, EN high 17 edges later
    task automatic apply(input logic [13:0] c, input logic [3:0] it, input logic [1:0] m,
                         input logic [127:0] e1, input logic [127:0] e2, input logic [127:0] e3);
        wait_idle();
        @(posedge CLK);
        #1;
        CREDIT   = c;
        ITEM_SEL = it;
        MSG      = m;
        push_exp(e1, e2, e3, cyc + 18);
    endtask

    initial begin
        int waited;
        RST      = 1'b1;
        CREDIT   = '0;
        ITEM_SEL = '0;
        MSG      = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk_int("reset_en", int'(OLED_EN), 0);
        chk_int("reset_busy", int'(BUSY), 0);
        chk_page("reset_page0", PAGE0, Blank);
        chk_page("reset_page1", PAGE1, Blank);
        chk_page("reset_page2", PAGE2, Blank);
        chk_page("reset_page3", PAGE3, Blank);

        @(posedge CLK);
        #1;
        RST = 1'b0;
        push_exp("CREDIT: $ 0.00  ", "ITEM: -         ", "INSERT COINS    ", cyc + 18);

        apply(14'd1234, 4'd7, 2'd1, "CREDIT: $12.34  ", "ITEM: 7         ", "VENDING...      ");
        apply(14'd16383, 4'd12, 2'd2, "CREDIT: $99.99  ", "ITEM: ?         ", "SOLD OUT        ");
        apply(14'd1000, 4'd9, 2'd0, "CREDIT: $10.00  ", "ITEM: 9         ", "INSERT COINS    ");
        apply(14'd9, 4'd10, 2'd3, "CREDIT: $ 0.09  ", "ITEM: ?         ", "NO CREDIT       ");
        apply(14'd10000, 4'd0, 2'd1, "CREDIT: $99.99  ", "ITEM: -         ", "VENDING...      ");

        // Mid-handshake change and revert: one extra identical pass afterwards
        apply(14'd500, 4'd3, 2'd3, "CREDIT: $ 5.00  ", "ITEM: 3         ", "NO CREDIT       ");
        waited = 0;
        while (!OLED_EN && waited < 100) begin
            @(negedge CLK);
            waited++;
        end
        chk_int("en_seen_for_wait_fin", int'(OLED_EN), 1);
        repeat (10) @(posedge CLK);
        #1;
        CREDIT = 14'd505;
        push_exp("CREDIT: $ 5.00  ", "ITEM: 3         ", "NO CREDIT       ", -1);
        repeat (5) @(posedge CLK);
        #1;
        CREDIT = 14'd500;
        @(negedge CLK);
        chk_int("still_in_handshake", int'(OLED_EN), 1);

        // Reset during CONVERT, then a forced refresh of the current inputs
        wait_idle();
        @(posedge CLK);
        #1;
        CREDIT   = 14'd4321;
        ITEM_SEL = 4'd1;
        MSG      = 2'd0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk_int("busy_in_convert", int'(BUSY), 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        push_exp("CREDIT: $43.21  ", "ITEM: 1         ", "INSERT COINS    ", cyc + 18);
        @(negedge CLK);
        chk_int("midrst_en", int'(OLED_EN), 0);
        chk_int("midrst_busy", int'(BUSY), 0);
        chk_page("midrst_page0", PAGE0, Blank);
        chk_page("midrst_page1", PAGE1, Blank);
        chk_page("midrst_page2", PAGE2, Blank);
        chk_page("midrst_page3", PAGE3, Blank);

        // Static inputs: only the timer build may redraw
        wait_idle();
        repeat (2500) @(posedge CLK);
        wait_idle();
        chk_int("queue_empty", sbq.size(), 0);
`ifdef REFRESH_TIMER_EN
        chk_int("timer_redraws_seen", int'(timer_hs >= 2), 1);
`else
        chk_int("handshake_count", hs_count, n_pushed);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
